instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Responder side of the instruction-fetch memory protocol. Accepts fetch requests (request + byte address) from the fetch stage, grants them subject to an outstanding-request limit, and returns the 32-bit instruction word with a valid strobe a fixed number of cycles later, strictly in order. Backing storage is a word array filled through a separate load port (program loader or bench), so one block provides both the memory model and its grant/latency behaviour for the core.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥4.
- LATENCY, 2, cycles from grant to response valid; legal 1..8.
- MAX_OUTSTANDING, 2, maximum in-flight granted requests; legal 1..LATENCY.

- clock  in  1  Clock; all state updates on rising edge.
- reset  in  1  Reset; synchronous, active-high.
- mem_en  in  1  Global enable; 0 blocks new grants but in-flight responses still complete.
- instr_req_ip  in  1  Fetch request valid.
- instr_addr_ip  in  32  Byte address of the request.
- flush_ip  in  1  Discard all in-flight responses.
- load_en_ip  in  1  Loader owns memory; no new grants while high.
- load_we_ip  in  1  Write strobe, honoured only when load_en_ip=1.
- load_addr_ip  in  32  Byte address of the load write.
- load_data_ip  in  32  Load write data.
- instr_gnt_op  out  1  Request accepted this cycle (combinational).
- instr_valid_op  out  1  Response data valid (registered).
- instr_data_op  out  32  Instruction word.
- instr_resp_addr_op  out  32  Byte address the response belongs to.
- outstanding_op  out  4  Current in-flight count.
- instr_err_op  out  1  Present only with IMEM_ERR_EN.

## Operation
- States: READY (grants permitted), LOADING (load_en_ip=1). READY→LOADING when load_en_ip=1; LOADING→READY when load_en_ip=0. Transitions take effect on the next edge; reset forces READY.
- Grant: instr_gnt_op = instr_req_ip & mem_en & state==READY & !load_en_ip & !flush_ip & (outstanding − retiring_this_cycle) < MAX_OUTSTANDING.
- Granted request enters a LATENCY-stage shift pipeline carrying {valid, addr}. Stage LATENCY-1 reads the array on its edge and drives instr_valid_op/data/resp_addr.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored; index wraps modulo DEPTH_WORDS.
- outstanding: +1 on grant, −1 on response retire; both in one cycle leaves it unchanged.
- flush_ip: all pipeline stages invalidated at the edge, outstanding←0, no grant that cycle; a response already valid in the flush cycle is still presented this cycle.
- Load write: array[load index] ← load_data_ip at edge when load_en_ip & load_we_ip. In-flight responses continue during LOADING. Same-edge write and response read of one word returns the old word (read-before-write).
- No backpressure: the consumer must accept every valid response.

## Timing
- Reset: instr_gnt_op=0, instr_valid_op=0, instr_data_op=0, instr_resp_addr_op=0, outstanding_op=0, instr_err_op=0, state READY, pipeline cleared. Array contents are NOT cleared.
- Grant on cycle t → instr_valid_op high for exactly one cycle at t+LATENCY.
- Back-to-back grants possible every cycle when MAX_OUTSTANDING=LATENCY; throughput = MAX_OUTSTANDING/LATENCY otherwise.
- Reset mid-operation discards all in-flight responses; no response appears after reset deasserts.
- instr_data_op/resp_addr_op hold last value when instr_valid_op=0.

## Configuration
- IMEM_ERR_EN defined: instr_err_op asserted with instr_valid_op when the request had addr[1:0]≠0 or addr ≥ 4·DEPTH_WORDS; instr_data_op then forced to 32'h00000013 (NOP). Index wrap does not occur for erroring requests.
- Undefined: instr_err_op port absent; misaligned/out-of-range addresses silently wrap as above.

## Test plan
- Load 0x00000000←32'h00500093, 0x4←32'h00100113; LATENCY=2; req 0x0 at t → gnt at t, valid at t+2, data 32'h00500093, resp_addr 0x0.
- LATENCY=2, MAX_OUTSTANDING=2, requests 0x0,0x4,0x8 on consecutive cycles → all granted, three valid pulses on t+2..t+4 in order; MAX_OUTSTANDING=1 → second request not granted until t+2, responses every 2 cycles.
- Two requests in flight, flush_ip at t+1 → no responses at t+2/t+3, outstanding_op=0 at t+2; req during flush cycle gets gnt=0.
- load_en_ip=1 with instr_req_ip=1 → gnt=0 throughout; earlier in-flight request still returns; write + same-word response read on one edge returns pre-write word.
- IMEM_ERR_EN: req 0x2 → err=1, data 32'h00000013; req 4·DEPTH_WORDS → err=1. Without macro: req 0x1000 (DEPTH 1024) returns word 0.
- Reset asserted with 2 in flight → valid stays 0 for LATENCY cycles after reset release, outstanding_op=0.

Source files
------------

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: responder side of the instruction-fetch memory protocol.
//
// Grants fetch requests under an outstanding-request limit and returns the
// addressed 32-bit word LATENCY cycles after the grant, in order. The backing
// word array is written through a separate load port. While the loader owns
// the memory (load_en_ip), no new grants are given, but in-flight responses
// still complete.
//
// Optional feature macro: IMEM_ERR_EN adds instr_err_op. Misaligned or
// out-of-range requests then return a NOP word and flag an error instead of
// wrapping the index.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   mem_en                global enable for new grants
//   instr_req_ip/addr_ip  fetch request and its byte address
//   flush_ip              discard every in-flight response
//   load_en/we/addr/data  loader write port (byte address)
//   instr_gnt_op          request accepted this cycle (combinational)
//   instr_valid_op        response strobe (registered)
//   instr_data_op         response word; holds its value while not valid
//   instr_resp_addr_op    byte address the response belongs to; holds too
//   outstanding_op        granted requests not yet retired
//   instr_err_op          error flag, only with IMEM_ERR_EN
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  input  logic        flush_ip,
  input  logic        load_en_ip,
  input  logic        load_we_ip,
  input  logic [31:0] load_addr_ip,
  input  logic [31:0] load_data_ip,
  output logic        instr_gnt_op,
  output logic        instr_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] instr_resp_addr_op,
  output logic [3:0]  outstanding_op
`ifdef IMEM_ERR_EN
  ,
  output logic        instr_err_op
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  localparam logic [0:0] StReady   = 1'b0;
  localparam logic [0:0] StLoading = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [31:0] data_q, data_d;

  // Stage LATENCY-1 is the output stage: its valid/addr drive the outputs.
  logic        pv_q [LATENCY];
  logic        pv_d [LATENCY];
  logic [31:0] pa_q [LATENCY];
  logic [31:0] pa_d [LATENCY];

  // Value shifting into each stage: the new grant for stage 0, else the
  // previous stage.
  logic        src_v [LATENCY];
  logic [31:0] src_a [LATENCY];

  logic [31:0] mem_q [DEPTH_WORDS];

  logic            retire;
  logic [3:0]      net_outstanding;
  logic            load_out;
  logic [IdxW-1:0] rd_idx;
  logic [IdxW-1:0] wr_idx;
  logic            wr_en;

`ifdef IMEM_ERR_EN
  logic err_q, err_d;
  logic rd_err;
`endif

  // Only the word-index bits of the load address select a word.
  logic unused_load_addr;
  assign unused_load_addr = ^{load_addr_ip[31:IdxW+2], load_addr_ip[1:0]};

  always_comb begin
    state_d = load_en_ip ? StLoading : StReady;

    // A response presented this cycle frees its slot for a same-cycle grant.
    retire          = pv_q[LATENCY-1];
    net_outstanding = outstanding_q - {3'b000, retire};

    instr_gnt_op = ~reset & instr_req_ip & mem_en & (state_q == StReady) & ~load_en_ip &
                   ~flush_ip & (net_outstanding < 4'(MAX_OUTSTANDING));

    outstanding_d = flush_ip ? 4'd0 : outstanding_q + {3'b000, instr_gnt_op} - {3'b000, retire};

    src_v[0] = instr_gnt_op;
    src_a[0] = instr_addr_ip;
    for (int i = 1; i < LATENCY; i++) begin
      src_v[i] = pv_q[i-1];
      src_a[i] = pa_q[i-1];
    end

    for (int i = 0; i < LATENCY; i++) begin
      pv_d[i] = src_v[i] & ~flush_ip;
      pa_d[i] = src_a[i];
    end

    // Output data/addr update only when a live response enters the output
    // stage; otherwise they keep the last presented response.
    load_out = src_v[LATENCY-1] & ~flush_ip;
    if (!load_out) begin
      pa_d[LATENCY-1] = pa_q[LATENCY-1];
    end

    rd_idx = src_a[LATENCY-1][IdxW+1:2];

`ifdef IMEM_ERR_EN
    rd_err = (src_a[LATENCY-1][1:0] != 2'b00) || (src_a[LATENCY-1][31:IdxW+2] != '0);
    err_d  = load_out & rd_err;
    data_d = load_out ? (rd_err ? 32'h0000_0013 : mem_q[rd_idx]) : data_q;
`else
    data_d = load_out ? mem_q[rd_idx] : data_q;
`endif

    wr_en  = load_en_ip & load_we_ip;
    wr_idx = load_addr_ip[IdxW+1:2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StReady;
      outstanding_q <= 4'd0;
      data_q        <= 32'd0;
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= 32'd0;
      end
`ifdef IMEM_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      data_q        <= data_d;
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= pv_d[i];
        pa_q[i] <= pa_d[i];
      end
`ifdef IMEM_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  // Array is not reset. The response read above sees the pre-write word when
  // a load write hits the same word on the same edge.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= load_data_ip;
    end
  end

  assign instr_valid_op     = pv_q[LATENCY-1];
  assign instr_resp_addr_op = pa_q[LATENCY-1];
  assign instr_data_op      = data_q;
  assign outstanding_op     = outstanding_q;
`ifdef IMEM_ERR_EN
  assign instr_err_op       = err_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Testbench for instr_mem_responder: directed protocol scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level
// model (queue of in-flight responses with due cycles, plus a word array).
module tb_instr_mem_responder;

  localparam int unsigned Depth  = 1024;
  localparam int unsigned Lat    = 2;
  localparam int unsigned MaxOut = 2;
  localparam logic [31:0] Nop    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en = 1'b0;
  logic        instr_req_ip = 1'b0;
  logic [31:0] instr_addr_ip = '0;
  logic        flush_ip = 1'b0;
  logic        load_en_ip = 1'b0;
  logic        load_we_ip = 1'b0;
  logic [31:0] load_addr_ip = '0;
  logic [31:0] load_data_ip = '0;
  logic        instr_gnt_op;
  logic        instr_valid_op;
  logic [31:0] instr_data_op;
  logic [31:0] instr_resp_addr_op;
  logic [3:0]  outstanding_op;
`ifdef IMEM_ERR_EN
  logic        instr_err_op;
`endif

  always #5 clock = ~clock;

  instr_mem_responder #(
    .DEPTH_WORDS    (Depth),
    .LATENCY        (Lat),
    .MAX_OUTSTANDING(MaxOut)
  ) u_dut (
    .clock             (clock),
    .reset             (reset),
    .mem_en            (mem_en),
    .instr_req_ip      (instr_req_ip),
    .instr_addr_ip     (instr_addr_ip),
    .flush_ip          (flush_ip),
    .load_en_ip        (load_en_ip),
    .load_we_ip        (load_we_ip),
    .load_addr_ip      (load_addr_ip),
    .load_data_ip      (load_data_ip),
    .instr_gnt_op      (instr_gnt_op),
    .instr_valid_op    (instr_valid_op),
    .instr_data_op     (instr_data_op),
    .instr_resp_addr_op(instr_resp_addr_op),
    .outstanding_op    (outstanding_op)
`ifdef IMEM_ERR_EN
    ,
    .instr_err_op      (instr_err_op)
`endif
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mdl_mem [Depth];
  logic [31:0] last_data;
  logic [31:0] last_addr;
  logic        mdl_loading;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic addr_err(input logic [31:0] a);
`ifdef IMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 4 * Depth);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, check the DUT
  // against the model, then advance the model across the next rising edge.
  task automatic step(input logic rst, input logic req, input logic [31:0] addr,
                      input logic en, input logic fl, input logic len, input logic we,
                      input logic [31:0] la, input logic [31:0] ld);
    logic        exp_valid;
    logic        exp_err;
    logic        exp_gnt;
    int unsigned net;
    @(negedge clock);
    reset         = rst;
    instr_req_ip  = req;
    instr_addr_ip = addr;
    mem_en        = en;
    flush_ip      = fl;
    load_en_ip    = len;
    load_we_ip    = we;
    load_addr_ip  = la;
    load_data_ip  = ld;
    #1;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (q.size() > 0) begin
      if (q[0].due == cyc) begin
        exp_valid = 1'b1;
        exp_err   = q[0].err;
        last_data = q[0].data;
        last_addr = q[0].addr;
      end
    end
    net     = q.size() - (exp_valid ? 1 : 0);
    exp_gnt = !rst && req && en && !mdl_loading && !len && !fl && (net < MaxOut);

    check_eq("gnt", {31'b0, instr_gnt_op}, {31'b0, exp_gnt});
    check_eq("valid", {31'b0, instr_valid_op}, {31'b0, exp_valid});
    check_eq("data", instr_data_op, last_data);
    check_eq("resp_addr", instr_resp_addr_op, last_addr);
    check_eq("outstanding", {28'b0, outstanding_op}, 32'(q.size()));
`ifdef IMEM_ERR_EN
    check_eq("err", {31'b0, instr_err_op}, {31'b0, exp_err});
`endif

    // Model edge: retire, accept, fetch data for next-cycle responses from
    // the pre-write array, then apply the load write.
    if (exp_valid) void'(q.pop_front());
    if (exp_gnt) q.push_back('{due: cyc + Lat, addr: addr, data: 32'd0, err: addr_err(addr)});
    foreach (q[i]) begin
      if (q[i].due == cyc + 1) begin
        q[i].data = q[i].err ? Nop : mdl_mem[(q[i].addr >> 2) % Depth];
      end
    end
    if (len && we) mdl_mem[(la >> 2) % Depth] = ld;
    if (rst || fl) q.delete();
    if (rst) begin
      last_data = 32'd0;
      last_addr = 32'd0;
    end
    mdl_loading = rst ? 1'b0 : len;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, 1, 0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(0, 1, a, 1, 0, 0, 0, 32'd0, 32'd0);
  endtask

  initial begin
    logic        r_rst, r_req, r_en, r_fl, r_we;
    logic [31:0] r_addr;
    logic        load_mode;
    int unsigned sel;

    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    last_data   = 32'd0;
    last_addr   = 32'd0;
    mdl_loading = 1'b0;
    load_mode   = 1'b0;

    repeat (2) @(posedge clock);

    // Reset state.
    step(1, 1, 32'd0, 1, 0, 0, 0, 32'd0, 32'd0);

    // Fill the whole array through the load port.
    for (int i = 0; i < Depth; i++) step(0, 1, 32'd0, 1, 0, 1, 1, 32'(i * 4), $urandom);
    step(0, 0, 32'd0, 1, 0, 1, 1, 32'h0, 32'h0050_0093);
    step(0, 0, 32'd0, 1, 0, 1, 1, 32'h4, 32'h0010_0113);
    // First cycle after load_en drops is still LOADING: no grant.
    step(0, 1, 32'h0, 1, 0, 0, 0, 32'd0, 32'd0);
    idle(2);

    // Single fetch: valid two cycles after grant with the loaded word.
    fetch(32'h0);
    idle(2);
    check_eq("tp_valid", {31'b0, instr_valid_op}, 32'd1);
    check_eq("tp_data", instr_data_op, 32'h0050_0093);
    check_eq("tp_resp_addr", instr_resp_addr_op, 32'h0);
    idle(2);

    // Back-to-back fetches.
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(4);

    // Flush with two in flight; request in the flush cycle is refused.
    fetch(32'h0);
    fetch(32'h4);
    step(0, 1, 32'h8, 1, 1, 0, 0, 32'd0, 32'd0);
    check_eq("tp_flush_gnt", {31'b0, instr_gnt_op}, 32'd0);
    idle(3);

    // Loading blocks grants; in-flight response still returns pre-write word.
    fetch(32'hC);
    step(0, 1, 32'hC, 1, 0, 1, 1, 32'hC, 32'hDEAD_BEEF);
    step(0, 1, 32'h10, 1, 0, 1, 0, 32'd0, 32'd0);
    step(0, 1, 32'h10, 1, 0, 1, 0, 32'd0, 32'd0);
    idle(2);
    fetch(32'hC);
    idle(3);

    // Misaligned and out-of-range addresses.
    fetch(32'h2);
    fetch(32'h1000);
    idle(3);
    fetch(32'h1004);
    idle(3);

    // Reset with two in flight.
    fetch(32'h0);
    fetch(32'h4);
    step(1, 1, 32'h8, 1, 0, 0, 0, 32'd0, 32'd0);
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_req = ($urandom_range(0, 9) < 7);
      r_en  = ($urandom_range(0, 9) != 0);
      r_fl  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) load_mode = ~load_mode;
      r_we  = load_mode && !r_rst && ($urandom_range(0, 1) == 1);
      sel   = $urandom_range(0, 7);
      if (sel < 6) begin
        r_addr = 32'($urandom_range(0, 63)) << 2;
      end else if (sel == 6) begin
        r_addr = 32'($urandom_range(0, 255));
      end else begin
        r_addr = 4 * Depth + 32'($urandom_range(0, 63));
      end
      step(r_rst, r_req, r_addr, r_en, r_fl, load_mode, r_we,
           32'($urandom_range(0, 63)) << 2, $urandom);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
